// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the buffered UART slice.
//   - CSR register offsets, selected by csr_a[1:0]
//   - STATUS bit positions
//   - TX sequencer state encoding
//   - reset divisor helper
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_DIV    = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_RX_NONEMPTY = 0;
  localparam int ST_RX_FULL     = 1;
  localparam int ST_TX_EMPTY    = 2;
  localparam int ST_TX_FULL     = 3;
  localparam int ST_RX_OVERRUN  = 4;
  localparam int ST_THRU        = 5;
  localparam int ST_TX_OVERFLOW = 6;
  localparam int ST_RX_LEVEL    = 8;
  localparam int ST_TX_LEVEL    = 16;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_t;

  // 16x oversampling divisor, truncated to the register width.
  function automatic logic [15:0] reset_divisor(input int clk_freq, input int baud);
    return 16'(clk_freq / baud / 16);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with first-word fall-through output.
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   push, din          : write request and data (dropped when full unless popped)
//   pop                : read request (ignored when empty)
//   dout               : current head, valid while !empty
//   full, empty, level : occupancy, level is depth_log2+1 bits
module uart_sync_fifo #(
  parameter int width      = 8,
  parameter int depth_log2 = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [width-1:0]      din,
  output logic [width-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [depth_log2:0]   level
);

  localparam int depth = 1 << depth_log2;
  localparam logic [depth_log2:0] ptr_one = 1;

  logic [width-1:0]    mem [depth];
  logic [depth_log2:0] wptr;
  logic [depth_log2:0] rptr;
  logic                do_push;
  logic                do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[depth_log2] != rptr[depth_log2]) &&
                 (wptr[depth_log2-1:0] == rptr[depth_log2-1:0]);

  // A pop on empty is ignored; a push on full proceeds only if a pop frees a slot.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign dout = mem[rptr[depth_log2-1:0]];

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + ptr_one;
      if (do_pop)  rptr <= rptr + ptr_one;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wptr[depth_log2-1:0]] <= din;
  end

endmodule

// File: rtl/uart_transceiver.sv
// uart_transceiver: 8N1 serial transmitter/receiver with 16x oversampling.
//   sys_clk, sys_rst   : clock, synchronous active-high reset
//   uart_rx, uart_tx   : serial pins (uart_tx idles high)
//   divisor            : sys_clk cycles per oversample tick
//   rx_data, rx_done   : received byte, one-cycle strobe on a good stop bit
//   tx_data, tx_wr     : byte to send, one-cycle start strobe
//   tx_done            : one-cycle strobe at the end of the stop bit
module uart_transceiver (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        uart_rx,
  output logic        uart_tx,
  input  logic [15:0] divisor,
  output logic [7:0]  rx_data,
  output logic        rx_done,
  input  logic [7:0]  tx_data,
  input  logic        tx_wr,
  output logic        tx_done
);

  logic [15:0] tick_cnt;
  logic        tick;

  // Down-counter; reloading whenever it sits above the new terminal value
  // makes a divisor change take effect at once, even mid-frame.
  assign tick = (tick_cnt == 16'd0);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) tick_cnt <= divisor - 16'd1;
    else if (tick || tick_cnt >= divisor) tick_cnt <= divisor - 16'd1;
    else tick_cnt <= tick_cnt - 16'd1;
  end

  logic       rx_s1, rx_s2;
  logic       rx_busy;
  logic [3:0] rx_cnt16;
  logic [3:0] rx_bitcnt;
  logic [7:0] rx_reg;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_busy   <= 1'b0;
      rx_done   <= 1'b0;
      rx_cnt16  <= '0;
      rx_bitcnt <= '0;
      rx_reg    <= '0;
      rx_data   <= '0;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_done <= 1'b0;
      if (tick) begin
        if (!rx_busy) begin
          if (!rx_s2) begin
            // Start at 7 so the wrap to 0 lands in the middle of each bit.
            rx_busy   <= 1'b1;
            rx_cnt16  <= 4'd7;
            rx_bitcnt <= 4'd0;
          end
        end else begin
          rx_cnt16 <= rx_cnt16 + 4'd1;
          if (rx_cnt16 == 4'd0) begin
            rx_bitcnt <= rx_bitcnt + 4'd1;
            if (rx_bitcnt == 4'd0) begin
              if (rx_s2) rx_busy <= 1'b0;
            end else if (rx_bitcnt == 4'd9) begin
              rx_busy <= 1'b0;
              if (rx_s2) begin
                rx_data <= rx_reg;
                rx_done <= 1'b1;
              end
            end else begin
              rx_reg <= {rx_s2, rx_reg[7:1]};
            end
          end
        end
      end
    end
  end

  logic       tx_busy;
  logic [3:0] tx_cnt16;
  logic [3:0] tx_bitcnt;
  logic [7:0] tx_reg;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      uart_tx   <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      tx_cnt16  <= '0;
      tx_bitcnt <= '0;
      tx_reg    <= '0;
    end else begin
      tx_done <= 1'b0;
      if (tx_wr) begin
        tx_reg    <= tx_data;
        tx_bitcnt <= 4'd0;
        tx_cnt16  <= 4'd1;
        tx_busy   <= 1'b1;
        uart_tx   <= 1'b0;
      end else if (tick && tx_busy) begin
        tx_cnt16 <= tx_cnt16 + 4'd1;
        if (tx_cnt16 == 4'd0) begin
          tx_bitcnt <= tx_bitcnt + 4'd1;
          if (tx_bitcnt == 4'd8) begin
            uart_tx <= 1'b1;
          end else if (tx_bitcnt == 4'd9) begin
            uart_tx <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
          end else begin
            uart_tx <= tx_reg[0];
            tx_reg  <= {1'b0, tx_reg[7:1]};
          end
        end
      end
    end
  end

endmodule

// File: rtl/uart_fifo.sv
// uart_fifo: CSR-mapped UART with RX/TX FIFOs, status, level irqs, sticky errors.
//   sys_clk, sys_rst_n      : clock, synchronous active-low reset
//   csr_a, csr_we, csr_di   : CSR access, bank csr_a[13:10], register csr_a[1:0]
//   csr_do                  : registered read data, 0 when not reading
//   rx_irq                  : rx_ie & RX not empty
//   tx_irq                  : tx_ie & TX empty & sequencer idle
//   uart_rx, uart_tx        : serial pins
// Optional build macro UART_FIFO_THRU_EN adds STATUS bit 5 (thru): uart_tx
// follows uart_rx combinationally while set.
//
// TX sequencer states:
//   TX_IDLE | transceiver free; pops the FIFO head and strobes tx_wr
//   TX_BUSY | frame in flight; waits for tx_done
module uart_fifo import uart_pkg::*; #(
  parameter logic [3:0] csr_addr        = 4'h0,
  parameter int         clk_freq        = 50000000,
  parameter int         baud            = 115200,
  parameter int         fifo_depth_log2 = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        rx_irq,
  output logic        tx_irq,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int          lvl_w     = fifo_depth_log2 + 1;
  localparam logic [15:0] div_reset = reset_divisor(clk_freq, baud);

  logic       csr_sel;
  logic [1:0] reg_sel;
  logic       wr_data, wr_div, wr_status, wr_ctrl, rd_data;

  assign csr_sel   = (csr_a[13:10] == csr_addr);
  assign reg_sel   = csr_a[1:0];
  assign wr_data   = csr_sel &  csr_we & (reg_sel == REG_DATA);
  assign wr_div    = csr_sel &  csr_we & (reg_sel == REG_DIV);
  assign wr_status = csr_sel &  csr_we & (reg_sel == REG_STATUS);
  assign wr_ctrl   = csr_sel &  csr_we & (reg_sel == REG_CTRL);
  assign rd_data   = csr_sel & ~csr_we & (reg_sel == REG_DATA);

  logic [15:0] divisor;
  logic        rx_ie, tx_ie;
  logic        rx_overrun, tx_overflow;
  logic        thru;

  logic [7:0]       rx_data, rx_dout, tx_dout, tx_data;
  logic             rx_done, tx_done, tx_wr, xcvr_tx;
  logic             rx_full, rx_empty, tx_full, tx_empty;
  logic [lvl_w-1:0] rx_level, tx_level;
  logic             tx_pop;
  tx_state_t        tx_state;

  uart_sync_fifo #(.width(8), .depth_log2(fifo_depth_log2)) u_rx_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (rx_done),
    .pop       (rd_data),
    .din       (rx_data),
    .dout      (rx_dout),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level)
  );

  uart_sync_fifo #(.width(8), .depth_log2(fifo_depth_log2)) u_tx_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (wr_data),
    .pop       (tx_pop),
    .din       (csr_di[7:0]),
    .dout      (tx_dout),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level)
  );

  uart_transceiver u_xcvr (
    .sys_clk (sys_clk),
    .sys_rst (~sys_rst_n),
    .uart_rx (uart_rx),
    .uart_tx (xcvr_tx),
    .divisor (divisor),
    .rx_data (rx_data),
    .rx_done (rx_done),
    .tx_data (tx_data),
    .tx_wr   (tx_wr),
    .tx_done (tx_done)
  );

  assign tx_pop = (tx_state == TX_IDLE) & ~tx_empty;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      tx_state <= TX_IDLE;
      tx_wr    <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_wr <= 1'b0;
      case (tx_state)
        TX_IDLE: if (!tx_empty) begin
          tx_data  <= tx_dout;
          tx_wr    <= 1'b1;
          tx_state <= TX_BUSY;
        end
        TX_BUSY: if (tx_done) tx_state <= TX_IDLE;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Sticky flags: a same-cycle set beats the write-1-to-clear.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      divisor     <= div_reset;
      rx_ie       <= 1'b0;
      tx_ie       <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      if (wr_div) divisor <= csr_di[15:0];
      if (wr_ctrl) begin
        rx_ie <= csr_di[0];
        tx_ie <= csr_di[1];
      end
      rx_overrun  <= (rx_done & rx_full & ~rd_data) |
                     (rx_overrun & ~(wr_status & csr_di[ST_RX_OVERRUN]));
      tx_overflow <= (wr_data & tx_full & ~tx_pop) |
                     (tx_overflow & ~(wr_status & csr_di[ST_TX_OVERFLOW]));
    end
  end

`ifdef UART_FIFO_THRU_EN
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) thru <= 1'b0;
    else if (wr_status) thru <= csr_di[ST_THRU];
  end
  assign uart_tx = thru ? uart_rx : xcvr_tx;
`else
  assign thru    = 1'b0;
  assign uart_tx = xcvr_tx;
`endif

  logic [31:0] status;
  always_comb begin
    status                          = '0;
    status[ST_RX_NONEMPTY]          = ~rx_empty;
    status[ST_RX_FULL]              = rx_full;
    status[ST_TX_EMPTY]             = tx_empty;
    status[ST_TX_FULL]              = tx_full;
    status[ST_RX_OVERRUN]           = rx_overrun;
    status[ST_THRU]                 = thru;
    status[ST_TX_OVERFLOW]          = tx_overflow;
    status[ST_RX_LEVEL +: lvl_w]    = rx_level;
    status[ST_TX_LEVEL +: lvl_w]    = tx_level;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      csr_do <= '0;
    end else begin
      csr_do <= '0;
      if (csr_sel && !csr_we) begin
        case (reg_sel)
          REG_DATA:   if (!rx_empty) csr_do <= {23'b0, 1'b1, rx_dout};
          REG_DIV:    csr_do <= {16'b0, divisor};
          REG_STATUS: csr_do <= status;
          REG_CTRL:   csr_do <= {30'b0, tx_ie, rx_ie};
          default:    csr_do <= '0;
        endcase
      end
    end
  end

  assign rx_irq = rx_ie & ~rx_empty;
  assign tx_irq = tx_ie & tx_empty & (tx_state == TX_IDLE);

  logic unused_csr_bits;
  assign unused_csr_bits = &{1'b0, csr_a[9:2], csr_di[31:16]};

endmodule

// File: tb/tb_uart_fifo.sv
module tb_uart_fifo;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic        rx_irq, tx_irq;
  logic        uart_tx;
  logic        uart_rx_w;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;

  int vectors = 0;
  int errors  = 0;

  logic [8:0] tx_frames [$];
  logic [7:0] mon_b;
  logic [31:0] rd;
  int          cyc;
  int          early;

  localparam logic [13:0] IDLE_A = 14'h0400;

  always #5 sys_clk = ~sys_clk;

  assign uart_rx_w = loop_en ? uart_tx : rx_drv;

  uart_fifo dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .csr_a     (csr_a),
    .csr_we    (csr_we),
    .csr_di    (csr_di),
    .csr_do    (csr_do),
    .rx_irq    (rx_irq),
    .tx_irq    (tx_irq),
    .uart_rx   (uart_rx_w),
    .uart_tx   (uart_tx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic csr_wr(input logic [1:0] addr, input logic [31:0] data);
    @(negedge sys_clk);
    csr_a  = {12'b0, addr};
    csr_we = 1'b1;
    csr_di = data;
    @(negedge sys_clk);
    csr_a  = IDLE_A;
    csr_we = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] addr, output logic [31:0] data);
    @(negedge sys_clk);
    csr_a  = {12'b0, addr};
    csr_we = 1'b0;
    @(negedge sys_clk);
    csr_a  = IDLE_A;
    data   = csr_do;
  endtask

  task automatic wait_frames(input string tag, input int n, input int budget);
    int c = 0;
    while (tx_frames.size() < n && c < budget) begin
      @(negedge sys_clk);
      c++;
    end
    check(tag, 32'(tx_frames.size()), 32'(n));
  endtask

  // Serial monitor at 16 clocks per bit (divisor 1): samples mid-bit.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n && uart_tx === 1'b0) begin
        repeat (8) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge sys_clk);
          mon_b[i] = uart_tx;
        end
        repeat (16) @(negedge sys_clk);
        tx_frames.push_back({uart_tx, mon_b});
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    csr_a  = IDLE_A;
    csr_we = 1'b0;
    csr_di = '0;
    repeat (4) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Reset state
    check("rst_rx_irq", {31'b0, rx_irq}, 32'd0);
    check("rst_tx_irq", {31'b0, tx_irq}, 32'd0);
    check("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
    check("rst_csr_do", csr_do, 32'd0);
    csr_rd(2, rd); check("rst_status", rd, 32'h0000_0004);
    csr_rd(1, rd); check("rst_divisor", rd, 32'd27);
    csr_wr(1, 32'd1);
    csr_rd(1, rd); check("divisor_rw", rd, 32'd1);

    // Two frames in order; tx_irq only after the second tx_done
    tx_frames.delete();
    csr_wr(0, 32'h55);
    csr_wr(0, 32'hA3);
    csr_wr(3, 32'h2);
    cyc = 0; early = 0;
    while (tx_frames.size() < 2 && cyc < 800) begin
      @(negedge sys_clk);
      if (tx_irq) early++;
      cyc++;
    end
    check("tx2_count", 32'(tx_frames.size()), 32'd2);
    check("tx_irq_early", 32'(early), 32'd0);
    if (tx_frames.size() >= 2) begin
      check("tx2_frame0", {23'b0, tx_frames[0]}, 32'h155);
      check("tx2_frame1", {23'b0, tx_frames[1]}, 32'h1A3);
    end
    cyc = 0;
    while (!tx_irq && cyc < 60) begin
      @(negedge sys_clk);
      cyc++;
    end
    check("tx_irq_rise", {31'b0, tx_irq}, 32'd1);

    // Loopback three bytes into RX
    csr_wr(3, 32'h1);
    loop_en = 1'b1;
    tx_frames.delete();
    csr_wr(0, 32'h55);
    csr_wr(0, 32'hA3);
    csr_wr(0, 32'h3C);
    wait_frames("loop3_frames", 3, 800);
    repeat (40) @(negedge sys_clk);
    check("loop3_rx_irq", {31'b0, rx_irq}, 32'd1);
    csr_rd(2, rd); check("loop3_status", rd, 32'h0000_0305);
    csr_rd(0, rd); check("loop3_rd0", rd, 32'h155);
    csr_rd(0, rd); check("loop3_rd1", rd, 32'h1A3);
    csr_rd(0, rd); check("loop3_rd2", rd, 32'h13C);
    csr_rd(0, rd); check("loop3_rd_empty", rd, 32'h0);
    check("loop3_rx_irq_drop", {31'b0, rx_irq}, 32'd0);
    csr_rd(2, rd); check("loop3_status_end", rd, 32'h0000_0004);

    // RX overrun: 17 bytes into a 16-deep FIFO
    tx_frames.delete();
    for (int i = 0; i < 17; i++) csr_wr(0, 32'(16 + i));
    wait_frames("ovr_frames", 17, 4000);
    repeat (40) @(negedge sys_clk);
    csr_rd(2, rd); check("ovr_status", rd, 32'h0000_1017);
    csr_wr(2, 32'h10);
    csr_rd(2, rd); check("ovr_w1c", rd, 32'h0000_1007);
    for (int i = 0; i < 16; i++) begin
      csr_rd(0, rd);
      check($sformatf("ovr_rd%0d", i), rd, 32'h100 | 32'(16 + i));
    end
    csr_rd(2, rd); check("ovr_status_end", rd, 32'h0000_0004);

    // TX overflow: one in flight plus 17 writes into 16 slots
    loop_en = 1'b0;
    csr_wr(3, 32'h0);
    tx_frames.delete();
    csr_wr(0, 32'h80);
    for (int i = 0; i < 17; i++) csr_wr(0, 32'(8'h81 + i));
    csr_rd(2, rd); check("txof_status", rd, 32'h0010_0048);
    wait_frames("txof_frames", 17, 4000);
    repeat (300) @(negedge sys_clk);
    check("txof_exact", 32'(tx_frames.size()), 32'd17);
    for (int i = 0; i < 17 && i < tx_frames.size(); i++)
      check($sformatf("txof_f%0d", i), {23'b0, tx_frames[i]}, 32'h180 + 32'(i));
    csr_wr(2, 32'h40);
    csr_rd(2, rd); check("txof_w1c", rd, 32'h0000_0004);

`ifdef UART_FIFO_THRU_EN
    csr_wr(2, 32'h20);
    csr_rd(2, rd); check("thru_status", rd, 32'h0000_0024);
    rx_drv = 1'b0; #1;
    check("thru_lo", {31'b0, uart_tx}, 32'd0);
    rx_drv = 1'b1; #1;
    check("thru_hi", {31'b0, uart_tx}, 32'd1);
    csr_wr(2, 32'h0);
`else
    csr_wr(2, 32'h20);
    csr_rd(2, rd); check("thru_ignored", rd, 32'h0000_0004);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
